rst_seq: RTL and testbench

- Generates the design's internal reset outputs from the synchronized global rst_n.
- Holds and stretches reset, then releases it in two stages: sys_rst_n first, per_rst_n after a gap.
- Logic inside the design can re-assert reset by software request or by watchdog expiry.
- Reports the cause of the last reset to status logic.

---
 rtl/rst_pkg.sv | 17 +
 rtl/wdog_timer.sv | 30 +++
 rtl/rst_seq.sv | 99 +++++++++
 tb/tb_rst_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: sequencer states and reset-cause codes.
package rst_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    HOLD  = 2'd1,
    STAGE = 2'd2,
    RUN   = 2'd3
  } rst_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_SOFT = 2'b01,
    CAUSE_WDOG = 2'b10
  } rst_cause_t;

endpackage

// File: rtl/wdog_timer.sv
// Watchdog counter: counts enabled cycles, clears on clr, flags expiry on the terminal count.
module wdog_timer #(
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int            CW   = $clog2(WDOG_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A kick on the terminal edge suppresses expiry.
  assign expire = en & ~clr & (cnt == LAST);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: stretches reset, releases sys_rst_n then per_rst_n, and re-asserts
// reset on software request or watchdog expiry while recording the cause.
module rst_seq
  import rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       wdog_en,
  input  logic       wdog_kick,
  output logic       sys_rst_n,
  output logic       per_rst_n,
  output logic [1:0] rst_cause,
  output logic       busy
);

  localparam int            CNT_MAX    = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int            CW         = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LOAD = CW'(STAGE_GAP - 1);

  rst_state_t    state;
  logic [CW-1:0] cnt;
  logic          wdog_expire;

  wdog_timer #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wdog_en && (state == RUN)),
    .clr   (wdog_kick),
    .expire(wdog_expire)
  );

  // Negedge clocking lets the releases land mid-cycle for posedge consumers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
      per_rst_n <= 1'b0;
      rst_cause <= CAUSE_POR;
      busy      <= 1'b1;
    end else begin
      case (state)
        RESET: begin
          state <= HOLD;
          cnt   <= HOLD_LOAD;
        end
        HOLD: begin
          if (soft_rst_req) begin
            cnt       <= HOLD_LOAD;
            rst_cause <= CAUSE_SOFT;
          end else if (cnt == '0) begin
            sys_rst_n <= 1'b1;
            cnt       <= STAGE_LOAD;
            state     <= STAGE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STAGE: begin
          if (soft_rst_req) begin
            sys_rst_n <= 1'b0;
            rst_cause <= CAUSE_SOFT;
            cnt       <= HOLD_LOAD;
            state     <= HOLD;
          end else if (cnt == '0) begin
            per_rst_n <= 1'b1;
            busy      <= 1'b0;
            state     <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          // Software request outranks a coincident watchdog expiry.
          if (soft_rst_req || wdog_expire) begin
            sys_rst_n <= 1'b0;
            per_rst_n <= 1'b0;
            busy      <= 1'b1;
            rst_cause <= soft_rst_req ? CAUSE_SOFT : CAUSE_WDOG;
            cnt       <= HOLD_LOAD;
            state     <= HOLD;
          end
        end
        default: begin
          state <= RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed scenarios plus random traffic against a timeline model.
module tb_rst_seq;

  localparam int H = 4;
  localparam int G = 2;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       wdog_en = 1'b0;
  logic       wdog_kick = 1'b0;
  logic       sys_rst_n;
  logic       per_rst_n;
  logic [1:0] rst_cause;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Timeline model: edges since the last reset trigger and the release point.
  int         m_t;
  int         m_rel;
  int         m_quiet;
  bit         m_first;
  logic       m_sys, m_per, m_busy;
  logic [1:0] m_cause;

  rst_seq #(.HOLD_CYCLES(H), .STAGE_GAP(G), .WDOG_CYCLES(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(soft_rst_req),
    .wdog_en     (wdog_en),
    .wdog_kick   (wdog_kick),
    .sys_rst_n   (sys_rst_n),
    .per_rst_n   (per_rst_n),
    .rst_cause   (rst_cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_por();
    m_t = 0; m_rel = H + 1; m_quiet = 0; m_first = 1'b1;
    m_sys = 1'b0; m_per = 1'b0; m_busy = 1'b1; m_cause = 2'b00;
  endtask

  task automatic model_edge();
    bit         trig;
    bit         run;
    logic [1:0] c;
    if (!rst_n) begin
      model_por();
    end else begin
      run  = m_per;
      trig = 1'b0;
      c    = 2'b00;
      if (m_first) begin
        m_first = 1'b0;
        m_t     = 1;
      end else begin
        if (soft_rst_req) begin
          trig = 1'b1; c = 2'b01;
        end else if (run && wdog_en && !wdog_kick && m_quiet == W - 1) begin
          trig = 1'b1; c = 2'b10;
        end
        if (trig) begin
          m_t = 0; m_rel = H; m_cause = c;
        end else if (m_t < 1000) begin
          m_t++;
        end
      end
      if (trig || !run || !wdog_en || wdog_kick) m_quiet = 0;
      else m_quiet++;
      m_sys  = (m_t >= m_rel);
      m_per  = (m_t >= m_rel + G);
      m_busy = !m_per;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_edge();
    @(posedge clk);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && !m_per; i++) cycle();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    model_por();
    n_cmp++;
    if ({sys_rst_n, per_rst_n, rst_cause, busy} !== 5'b00_00_1) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", {sys_rst_n, per_rst_n, rst_cause, busy}, 5'b00001);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_power_on();
    int   sys_at, per_at, busy_at;
    logic ps, pp, pb;
    sys_at = -1; per_at = -1; busy_at = -1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      ps = sys_rst_n; pp = per_rst_n; pb = busy;
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL por_edge%0d: got %b want %b", k, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
      if (!ps && sys_rst_n && sys_at < 0) sys_at = k;
      if (!pp && per_rst_n && per_at < 0) per_at = k;
      if (pb && !busy && busy_at < 0) busy_at = k;
    end
    n_cmp++;
    if (sys_at != 5 || per_at != 7 || busy_at != 7) begin
      n_fail++;
      $display("FAIL por_release: got sys %0d per %0d busy %0d want 5 7 7", sys_at, per_at, busy_at);
    end
  endtask

  task automatic test_soft();
    int   len, rise_at;
    logic ps;
    wait_run();
    repeat ($urandom_range(1, 4)) cycle();
    len = $urandom_range(1, 5);
    rise_at = -1;
    soft_rst_req = 1'b1;
    for (int k = 1; k <= len + 10; k++) begin
      ps = sys_rst_n;
      cycle();
      if (k == len) soft_rst_req = 1'b0;
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL soft_len%0d_edge%0d: got %b want %b", len, k,
                 {sys_rst_n, per_rst_n, rst_cause, busy}, {m_sys, m_per, m_cause, m_busy});
      end
      if (!ps && sys_rst_n && rise_at < 0) rise_at = k;
    end
    n_cmp++;
    if (rise_at != len + H) begin
      n_fail++;
      $display("FAIL soft_release: got edge %0d want %0d", rise_at, len + H);
    end
  endtask

  task automatic test_wdog_expire();
    int hit;
    wdog_en = 1'b0;
    wait_run();
    wdog_en = 1'b1;
    hit = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL wdog_edge%0d: got %b want %b", k, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
      if (!sys_rst_n && hit < 0) begin
        hit = k;
        n_cmp++;
        if (rst_cause !== 2'b10) begin
          n_fail++;
          $display("FAIL wdog_cause: got %b want 10", rst_cause);
        end
      end
    end
    n_cmp++;
    if (hit != W) begin
      n_fail++;
      $display("FAIL wdog_expiry_edge: got %0d want %0d", hit, W);
    end
  endtask

  task automatic test_wdog_kicks();
    int resets;
    resets = 0;
    wait_run();
    for (int i = 0; i < 50; i++) begin
      wdog_kick = (i % 5 == 0);
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL kick_cyc%0d: got %b want %b", i, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
      if (!sys_rst_n) resets++;
    end
    wdog_kick = 1'b0;
    n_cmp++;
    if (resets != 0) begin
      n_fail++;
      $display("FAIL kick_no_reset: got %0d reset cycles want 0", resets);
    end
  endtask

  task automatic test_kick_at_expiry();
    int hit;
    wdog_kick = 1'b1;
    cycle();
    wdog_kick = 1'b0;
    repeat (W - 1) cycle();
    wdog_kick = 1'b1;
    cycle();
    wdog_kick = 1'b0;
    n_cmp++;
    if ({sys_rst_n, per_rst_n, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL kick_at_expiry: got %b want 110", {sys_rst_n, per_rst_n, busy});
    end
    hit = -1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL post_kick_edge%0d: got %b want %b", k, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
      if (!sys_rst_n) hit = k;
    end
    n_cmp++;
    if (hit != W) begin
      n_fail++;
      $display("FAIL kick_restart: got expiry at %0d want %0d", hit, W);
    end
  endtask

  task automatic test_stage_soft();
    int   rise_at;
    logic ps;
    wdog_en = 1'b0;
    for (int i = 0; i < 30 && !(m_sys && !m_per); i++) cycle();
    soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0;
    n_cmp++;
    if ({sys_rst_n, per_rst_n, rst_cause, busy} !== 5'b00_01_1) begin
      n_fail++;
      $display("FAIL stage_soft: got %b want 00011", {sys_rst_n, per_rst_n, rst_cause, busy});
    end
    rise_at = -1;
    for (int k = 1; k <= 10; k++) begin
      ps = sys_rst_n;
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL stage_soft_edge%0d: got %b want %b", k, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
      if (!ps && sys_rst_n && rise_at < 0) rise_at = k;
    end
    n_cmp++;
    if (rise_at != H) begin
      n_fail++;
      $display("FAIL stage_soft_hold: got edge %0d want %0d", rise_at, H);
    end
  endtask

  task automatic test_rst_mid_hold();
    wait_run();
    soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_por();
    n_cmp++;
    if ({sys_rst_n, per_rst_n, rst_cause, busy} !== 5'b00_00_1) begin
      n_fail++;
      $display("FAIL async_mid_hold: got %b want 00001", {sys_rst_n, per_rst_n, rst_cause, busy});
    end
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL after_async_edge%0d: got %b want %b", k, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (rst_n && $urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_por();
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      soft_rst_req = ($urandom_range(0, 24) == 0);
      wdog_kick    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) wdog_en = ~wdog_en;
      cycle();
      n_cmp++;
      if ({sys_rst_n, per_rst_n, rst_cause, busy} !== {m_sys, m_per, m_cause, m_busy}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %b want %b", i, {sys_rst_n, per_rst_n, rst_cause, busy},
                 {m_sys, m_per, m_cause, m_busy});
      end
    end
    rst_n = 1'b1;
    soft_rst_req = 1'b0;
    wdog_kick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    repeat (3) test_soft();
    test_wdog_expire();
    test_wdog_kicks();
    test_kick_at_expiry();
    test_stage_soft();
    test_rst_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
